// File: rtl/commit_trace_recorder_if.sv
// Commit-event and trace-beat bundle between the core commit stage, the recorder and the beat sink.
interface commit_trace_recorder_if;
  logic        i_cmt_valid;
  logic        i_cmt_skip;
  logic        i_cmt_wen;
  logic [4:0]  i_cmt_wdest;
  logic [63:0] i_cmt_wdata;
  logic [63:0] i_cmt_pc;
  logic [31:0] i_cmt_inst;
  logic [63:0] i_a0;
  logic        o_beat_valid;
  logic [31:0] o_beat_data;
  logic        o_beat_last;
  logic        i_beat_ready;

  modport slave (
    input  i_cmt_valid, i_cmt_skip, i_cmt_wen, i_cmt_wdest, i_cmt_wdata,
    input  i_cmt_pc, i_cmt_inst, i_a0, i_beat_ready,
    output o_beat_valid, o_beat_data, o_beat_last
  );

  modport master (
    output i_cmt_valid, i_cmt_skip, i_cmt_wen, i_cmt_wdest, i_cmt_wdata,
    output i_cmt_pc, i_cmt_inst, i_a0, i_beat_ready,
    input  o_beat_valid, o_beat_data, o_beat_last
  );
endinterface

// File: rtl/commit_trace_recorder.sv
// Buffers retired-instruction records and streams each as six 32-bit beats;
// also tracks cycle/instret/drop counters and latches the good-trap event.
module commit_trace_recorder #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  commit_trace_recorder_if.slave bus,
  output logic                   o_trap,
  output logic [2:0]             o_trap_code,
  output logic [63:0]            o_trap_pc,
  output logic [63:0]            o_cycle_cnt,
  output logic [63:0]            o_instr_cnt,
  output logic [DROP_W-1:0]      o_drop_cnt,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  typedef struct packed {
    logic        skip;
    logic        wen;
    logic [4:0]  wdest;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] wdata;
  } rec_t;

  rec_t              mem_q [DEPTH];
  rec_t              new_rec;
  rec_t              head;
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
  logic [2:0]        idx_q, idx_d;
  logic              trap_q, trap_d;
  logic [2:0]        code_q, code_d;
  logic [63:0]       tpc_q, tpc_d, cyc_q, cyc_d, instr_q, instr_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [31:0]       beat;
  logic              empty, full, accept, is_trap, hs, pop, push, drop;
  logic              unused_a0_hi;

  assign unused_a0_hi = ^bus.i_a0[63:3];

  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign accept  = bus.i_cmt_valid & ~trap_q;
  assign is_trap = accept & (bus.i_cmt_inst[6:0] == 7'h6b);
  assign hs      = ~empty & bus.i_beat_ready;
  assign pop     = hs & (idx_q == 3'd5);
  // A full FIFO still takes a record when its head leaves on this same edge.
  assign push    = accept & (~full | pop);
  assign drop    = accept & ~push;

  assign new_rec = '{skip: bus.i_cmt_skip, wen: bus.i_cmt_wen, wdest: bus.i_cmt_wdest,
                     pc: bus.i_cmt_pc, inst: bus.i_cmt_inst, wdata: bus.i_cmt_wdata};

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= new_rec;
    end
  end

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    beat = '0;
    case (idx_q)
      3'd0: beat = {8'hA5, 13'd0, head.skip, head.wen, 4'd0, head.wdest};
      3'd1: beat = head.pc[31:0];
      3'd2: beat = head.pc[63:32];
      3'd3: beat = head.inst;
      3'd4: beat = head.wdata[31:0];
      3'd5: beat = head.wdata[63:32];
      default: beat = '0;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    idx_d    = idx_q;
    if (hs) begin
      idx_d = pop ? 3'd0 : idx_q + 3'd1;
    end
    trap_d  = trap_q | is_trap;
    code_d  = is_trap ? bus.i_a0[2:0] : code_q;
    tpc_d   = is_trap ? bus.i_cmt_pc : tpc_q;
    // The trap cycle itself is counted because trap_q is still low during it.
    cyc_d   = trap_q ? cyc_q : cyc_q + 64'd1;
    instr_d = accept ? instr_q + 64'd1 : instr_q;
    drop_d  = (drop && (drop_q != '1)) ? drop_q + DROP_W'(1) : drop_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      idx_q    <= '0;
      trap_q   <= 1'b0;
      code_q   <= '0;
      tpc_q    <= '0;
      cyc_q    <= '0;
      instr_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      idx_q    <= idx_d;
      trap_q   <= trap_d;
      code_q   <= code_d;
      tpc_q    <= tpc_d;
      cyc_q    <= cyc_d;
      instr_q  <= instr_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.o_beat_valid = ~empty;
  assign bus.o_beat_data  = empty ? 32'd0 : beat;
  assign bus.o_beat_last  = ~empty & (idx_q == 3'd5);
  assign o_trap      = trap_q;
  assign o_trap_code = code_q;
  assign o_trap_pc   = tpc_q;
  assign o_cycle_cnt = cyc_q;
  assign o_instr_cnt = instr_q;
  assign o_drop_cnt  = drop_q;
  assign o_level     = level;
endmodule

// File: tb/tb_commit_trace_recorder.sv
// Randomized bench for commit_trace_recorder against a queue-of-beats reference model.
module tb_commit_trace_recorder;
  localparam int DEPTH  = 8;
  localparam int DROP_W = 16;

  typedef struct {
    logic        skip;
    logic        wen;
    logic [4:0]  wdest;
    logic [63:0] wdata;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] a0;
  } cmt_t;

  typedef struct {
    logic [31:0] d;
    logic        last;
  } beat_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   trap;
  logic [2:0]             trap_code;
  logic [63:0]            trap_pc, cycle_cnt, instr_cnt;
  logic [DROP_W-1:0]      drop_cnt;
  logic [$clog2(DEPTH):0] level;

  commit_trace_recorder_if bus();

  commit_trace_recorder #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .o_trap(trap), .o_trap_code(trap_code), .o_trap_pc(trap_pc),
    .o_cycle_cnt(cycle_cnt), .o_instr_cnt(instr_cnt),
    .o_drop_cnt(drop_cnt), .o_level(level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  beat_t             exp_q[$];
  int                m_recs;
  logic [63:0]       m_cyc, m_instr, m_tpc;
  logic [DROP_W-1:0] m_drop;
  logic              m_trap;
  logic [2:0]        m_code;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic cmt_t rand_cmt();
    cmt_t c;
    c.skip  = 1'($urandom_range(0, 1));
    c.wen   = 1'($urandom_range(0, 1));
    c.wdest = 5'($urandom_range(0, 31));
    c.wdata = {$urandom, $urandom};
    c.pc    = {$urandom, $urandom};
    c.inst  = $urandom;
    if (c.inst[6:0] == 7'h6b) c.inst[0] = ~c.inst[0];
    c.a0    = {$urandom, $urandom};
    return c;
  endfunction

  function automatic void model_push(input cmt_t c);
    logic [31:0] w [6];
    w[0] = {8'hA5, 13'd0, c.skip, c.wen, 4'd0, c.wdest};
    w[1] = c.pc[31:0];
    w[2] = c.pc[63:32];
    w[3] = c.inst;
    w[4] = c.wdata[31:0];
    w[5] = c.wdata[63:32];
    for (int k = 0; k < 6; k++) exp_q.push_back('{d: w[k], last: (k == 5)});
    m_recs++;
  endfunction

  // Drive one cycle at the negedge, check outputs, advance model across the posedge.
  task automatic cycle(input cmt_t c, input logic v, input logic rdy);
    logic hs, pop_last, acc, full;
    bus.i_cmt_valid  = v;
    bus.i_cmt_skip   = c.skip;
    bus.i_cmt_wen    = c.wen;
    bus.i_cmt_wdest  = c.wdest;
    bus.i_cmt_wdata  = c.wdata;
    bus.i_cmt_pc     = c.pc;
    bus.i_cmt_inst   = c.inst;
    bus.i_a0         = c.a0;
    bus.i_beat_ready = rdy;
    chk_eq("beat_valid", 64'(bus.o_beat_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk_eq("beat_data", 64'(bus.o_beat_data), 64'(exp_q[0].d));
      chk_eq("beat_last", 64'(bus.o_beat_last), 64'(exp_q[0].last));
    end
    chk_eq("level", 64'(level), 64'(m_recs));
    chk_eq("instr_cnt", instr_cnt, m_instr);
    chk_eq("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk_eq("cycle_cnt", cycle_cnt, m_cyc);
    chk_eq("trap", 64'(trap), 64'(m_trap));
    chk_eq("trap_code", 64'(trap_code), 64'(m_code));
    chk_eq("trap_pc", trap_pc, m_tpc);

    hs       = (exp_q.size() != 0) && rdy;
    pop_last = hs && exp_q[0].last;
    acc      = v && !m_trap;
    full     = (m_recs == DEPTH);
    if (hs) begin
      void'(exp_q.pop_front());
      if (pop_last) m_recs--;
    end
    if (!m_trap) m_cyc++;
    if (acc) begin
      m_instr++;
      if (!full || pop_last) model_push(c);
      else if (m_drop != '1) m_drop++;
      if (c.inst[6:0] == 7'h6b) begin
        m_trap = 1'b1;
        m_code = c.a0[2:0];
        m_tpc  = c.pc;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    cmt_t z;
    z = '{default: '0};
    bus.i_cmt_valid  = 1'b0;
    bus.i_beat_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_recs = 0; m_cyc = '0; m_instr = '0; m_drop = '0;
    m_trap = 1'b0; m_code = '0; m_tpc = '0;
    chk_eq("rst_valid", 64'(bus.o_beat_valid), 64'd0);
    chk_eq("rst_data", 64'(bus.o_beat_data), 64'd0);
    chk_eq("rst_last", 64'(bus.o_beat_last), 64'd0);
    chk_eq("rst_level", 64'(level), 64'd0);
    chk_eq("rst_cycle", cycle_cnt, 64'd0);
    chk_eq("rst_instr", instr_cnt, 64'd0);
    chk_eq("rst_drop", 64'(drop_cnt), 64'd0);
    chk_eq("rst_trap", {61'd0, trap_code}, 64'd0);
    chk_eq("rst_trap_flag", 64'(trap), 64'd0);
    chk_eq("rst_trap_pc", trap_pc, 64'd0);
    bus.i_cmt_valid = z.skip;
  endtask

  task automatic drain(input string tag);
    cmt_t z;
    int   n;
    z = '{default: '0};
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      cycle(z, 1'b0, 1'($urandom_range(0, 1)));
      n++;
    end
    chk_eq(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    cmt_t        c, z;
    logic [31:0] t1_beats [6];
    int          sent, guard;
    z = '{default: '0};
    bus.i_cmt_valid = 1'b0; bus.i_cmt_skip = 1'b0; bus.i_cmt_wen = 1'b0;
    bus.i_cmt_wdest = '0; bus.i_cmt_wdata = '0; bus.i_cmt_pc = '0;
    bus.i_cmt_inst = '0; bus.i_a0 = '0; bus.i_beat_ready = 1'b0;
    do_reset();

    // Single known record streamed with ready held high
    c = '{skip: 1'b0, wen: 1'b1, wdest: 5'd1, wdata: 64'd1,
          pc: 64'h8000_0000, inst: 32'h0010_0093, a0: 64'd0};
    t1_beats[0] = 32'hA500_0201; t1_beats[1] = 32'h8000_0000; t1_beats[2] = 32'h0;
    t1_beats[3] = 32'h0010_0093; t1_beats[4] = 32'h1;         t1_beats[5] = 32'h0;
    cycle(c, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      chk_eq("t1_beat", 64'(bus.o_beat_data), 64'(t1_beats[k]));
      chk_eq("t1_last", 64'(bus.o_beat_last), 64'(k == 5));
      cycle(z, 1'b0, 1'b1);
    end
    chk_eq("t1_empty", 64'(bus.o_beat_valid), 64'd0);

    // Overflow with the sink stalled, then a commit on the last-beat handshake
    do_reset();
    for (int k = 0; k < DEPTH + 3; k++) cycle(rand_cmt(), 1'b1, 1'b0);
    chk_eq("ovf_level", 64'(level), 64'(DEPTH));
    chk_eq("ovf_drop", 64'(drop_cnt), 64'd3);
    chk_eq("ovf_instr", instr_cnt, 64'(DEPTH + 3));
    for (int k = 0; k < 5; k++) cycle(z, 1'b0, 1'b1);
    chk_eq("pre_last", 64'(bus.o_beat_last), 64'd1);
    cycle(rand_cmt(), 1'b1, 1'b1);
    chk_eq("same_cyc_level", 64'(level), 64'(DEPTH));
    chk_eq("same_cyc_drop", 64'(drop_cnt), 64'd3);
    drain("ovf_drain");

    // Good-trap at cycle 20 followed by ignored commits
    do_reset();
    while (m_cyc < 64'd5) cycle(z, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) cycle(rand_cmt(), 1'b1, 1'b1);
    while (m_cyc < 64'd20) cycle(z, 1'b0, 1'b1);
    chk_eq("trap_at_20", cycle_cnt, 64'd20);
    c = rand_cmt();
    c.inst = 32'h0000_006b;
    c.a0   = 64'd0;
    cycle(c, 1'b1, 1'b1);
    cycle(rand_cmt(), 1'b1, 1'b1);
    cycle(rand_cmt(), 1'b1, 1'b1);
    chk_eq("trap_set", 64'(trap), 64'd1);
    chk_eq("trap_frozen", cycle_cnt, 64'd21);
    chk_eq("trap_instr", instr_cnt, 64'd6);
    chk_eq("trap_pc_val", trap_pc, c.pc);
    drain("trap_drain");
    for (int k = 0; k < 4; k++) cycle(rand_cmt(), 1'b1, 1'b1);
    chk_eq("trap_frozen_late", cycle_cnt, 64'd21);

    // Reset in the middle of a record with more queued behind it
    do_reset();
    for (int k = 0; k < 3; k++) cycle(rand_cmt(), 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cycle(z, 1'b0, 1'b1);
    chk_eq("mid_level", 64'(level), 64'd3);
    do_reset();

    // Random commits with random backpressure
    sent  = 0;
    guard = 0;
    while (sent < 100 && guard < 5000) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      cycle(rand_cmt(), v, 1'($urandom_range(0, 1)));
      if (v) sent++;
      guard++;
    end
    chk_eq("rand_sent", 64'(sent), 64'd100);
    chk_eq("rand_instr", instr_cnt, 64'd100);
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
